// File: rtl/dffnq_serial_deser.sv
// dffnq_serial_deser: falling-edge serial-to-parallel capture with a 2-entry word buffer.
// Latency: a word is visible on o_q/o_q_valid right after the falling edge that carries its last bit.
// Backpressure: o_q_valid/i_q_ready handshake; a word completing into a full buffer with no pop is dropped and sets o_overrun.
//
// Optional feature macro: DFFNQ_DESER_PARITY_EN. When it is defined, each word carries one
// extra even-parity bit after the data bits, and o_q_perr flags the head word. When it is
// undefined, no parity logic is built and o_q_perr is tied to 0.
//
// Ports:
//   i_clkn     clock; all state updates on the falling edge
//   i_rst      asynchronous reset, active-high
//   i_d        serial data bit, LSB first
//   i_frame    high on the edge that carries bit 0 of a word (also resyncs a partial word)
//   o_q        head-of-buffer word
//   o_q_valid  buffer non-empty
//   i_q_ready  consumer pops the head when o_q_valid && i_q_ready at a falling edge
//   o_q_perr   parity error flag of the head word
//   o_overrun  sticky: a completed word was dropped
//   i_clr_ovr  clears o_overrun (a new drop on the same edge wins)
module dffnq_serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic             i_clkn,
  input  logic             i_rst,
  input  logic             i_d,
  input  logic             i_frame,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_valid,
  input  logic             i_q_ready,
  output logic             o_q_perr,
  output logic             o_overrun,
  input  logic             i_clr_ovr
);

`ifdef DFFNQ_DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LEN = WIDTH + PAR;         // serial bits per word
  localparam int CW  = $clog2(WIDTH + 1);   // bit counter width
  localparam int EW  = WIDTH + PAR;         // buffer entry: data plus optional error flag

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_bitcnt;
  logic [LEN-1:0]  r_sh;
  logic [LEN-1:0]  w_full;
  logic [EW-1:0]   w_entry;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic [1:0]      r_cnt;
  logic [EW-1:0]   r_e0;
  logic [EW-1:0]   r_e1;
  logic            r_ovr;

  // Shift register with the current bit merged in at the counter position;
  // on the completing edge this is the whole word.
  always_comb begin
    w_full = r_sh;
    for (int i = 0; i < LEN; i++) begin
      if (r_bitcnt == CW'(i)) w_full[i] = i_d;
    end
  end

  assign w_push = (r_state == S_SHIFT) && !i_frame && (r_bitcnt == CW'(LEN - 1));
  assign w_pop  = (r_cnt != 2'd0) && i_q_ready;
  assign w_drop = w_push && (r_cnt == 2'd2) && !w_pop;

`ifdef DFFNQ_DESER_PARITY_EN
  // Even parity over data plus parity bit; the flag is stored with its word.
  assign w_entry  = {^w_full, w_full[WIDTH-1:0]};
  assign o_q_perr = r_e0[WIDTH];
`else
  assign w_entry  = w_full;
  assign o_q_perr = 1'b0;
`endif

  assign o_q       = r_e0[WIDTH-1:0];
  assign o_q_valid = (r_cnt != 2'd0);
  assign o_overrun = r_ovr;

  // Framing FSM
  always_ff @(negedge i_clkn or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_sh     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_frame) begin
            r_sh     <= {{(LEN-1){1'b0}}, i_d};
            r_bitcnt <= CW'(1);
            r_state  <= S_SHIFT;
          end
        end
        default: begin
          if (i_frame) begin
            // Resync: partial word silently discarded, this edge is bit 0.
            r_sh     <= {{(LEN-1){1'b0}}, i_d};
            r_bitcnt <= CW'(1);
          end else if (w_push) begin
            r_sh     <= w_full;
            r_bitcnt <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_sh     <= w_full;
            r_bitcnt <= r_bitcnt + CW'(1);
          end
        end
      endcase
    end
  end

  // 2-entry in-order buffer: r_e0 is the head. r_e0 keeps its value when the
  // buffer drains so o_q holds the last word.
  always_ff @(negedge i_clkn or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 2'd0;
      r_e0  <= '0;
      r_e1  <= '0;
      r_ovr <= 1'b0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_e0  <= w_entry;
            r_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_e0 <= w_entry;
          end else if (w_pop) begin
            r_cnt <= 2'd0;
          end else if (w_push) begin
            r_e1  <= w_entry;
            r_cnt <= 2'd2;
          end
        end
        default: begin
          if (w_pop) begin
            r_e0 <= r_e1;
            if (w_push) r_e1 <= w_entry;
            else        r_cnt <= 2'd1;
          end
        end
      endcase

      if (w_drop)         r_ovr <= 1'b1;
      else if (i_clr_ovr) r_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dffnq_serial_deser.sv
// tb_dffnq_serial_deser: directed self-checking bench for dffnq_serial_deser (WIDTH=8).
// Inputs change 1 time unit after each falling edge; outputs are sampled at that point.
// Parity-specific steps are compiled in when DFFNQ_DESER_PARITY_EN is defined.
module tb_dffnq_serial_deser;
  localparam int W = 8;

  logic         clkn = 1'b0;
  logic         rst  = 1'b1;
  logic         d    = 1'b0;
  logic         frame = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready = 1'b0;
  logic         q_perr;
  logic         overrun;
  logic         clr_ovr = 1'b0;

  int errors = 0;
  int checks = 0;

  dffnq_serial_deser #(.WIDTH(W)) dut (
    .i_clkn    (clkn),
    .i_rst     (rst),
    .i_d       (d),
    .i_frame   (frame),
    .o_q       (q),
    .o_q_valid (q_valid),
    .i_q_ready (q_ready),
    .o_q_perr  (q_perr),
    .o_overrun (overrun),
    .i_clr_ovr (clr_ovr)
  );

  always #5 clkn = ~clkn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One falling edge with the given inputs; returns 1 unit after the edge.
  task automatic tick(input logic f, input logic b, input logic rdy, input logic clr);
    frame   = f;
    d       = b;
    q_ready = rdy;
    clr_ovr = clr;
    @(negedge clkn);
    #1;
    frame   = 1'b0;
    q_ready = 1'b0;
    clr_ovr = 1'b0;
  endtask

  // Send one framed word LSB first; rdy_last drives i_q_ready on the completing edge.
  // In the parity build the parity bit par is sent after the data bits.
  task automatic send_word(input logic [W-1:0] w, input logic par, input logic rdy_last);
`ifdef DFFNQ_DESER_PARITY_EN
    for (int i = 0; i < W; i++) tick(i == 0, w[i], 1'b0, 1'b0);
    tick(1'b0, par, rdy_last, 1'b0);
`else
    for (int i = 0; i < W - 1; i++) tick(i == 0, w[i], 1'b0, 1'b0);
    tick(1'b0, w[W-1], rdy_last, 1'b0);
    if (par) ; // parity bit is not part of the word in this build
`endif
  endtask

  initial begin
    logic [W-1:0] a5;
    a5 = 8'hA5;

    // Reset values while reset is held
    #3;
    check("rst_q", 32'(q), 32'h0);
    check("rst_valid", 32'(q_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_perr", 32'(q_perr), 32'h0);
    rst = 1'b0;

    // Idle: FRAME low, D toggling, nothing must be captured
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, i[0], 1'b0, 1'b0);
      check("idle_valid", 32'(q_valid), 32'h0);
    end
    check("idle_q", 32'(q), 32'h0);
    check("idle_overrun", 32'(overrun), 32'h0);

    // A5 LSB first: 1,0,1,0,0,1,0,1
    for (int i = 0; i < W; i++) begin
      tick(i == 0, a5[i], 1'b0, 1'b0);
      if (i < W - 1) check("a5_partial_valid", 32'(q_valid), 32'h0);
    end
`ifdef DFFNQ_DESER_PARITY_EN
    check("a5_wait_parity_valid", 32'(q_valid), 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
`endif
    check("a5_q", 32'(q), 32'hA5);
    check("a5_valid", 32'(q_valid), 32'h1);
    check("a5_perr", 32'(q_perr), 32'h0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_pop_valid", 32'(q_valid), 32'h0);
    check("a5_hold_q", 32'(q), 32'hA5);
    // Ready with empty buffer must not disturb anything
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("empty_ready_valid", 32'(q_valid), 32'h0);

    // Overrun: 11, 22, 33 with no consumer
    send_word(8'h11, 1'b0, 1'b0);
    check("ovr_w1_q", 32'(q), 32'h11);
    check("ovr_w1_valid", 32'(q_valid), 32'h1);
    send_word(8'h22, 1'b0, 1'b0);
    check("ovr_w2_q", 32'(q), 32'h11);
    check("ovr_w2_overrun", 32'(overrun), 32'h0);
    send_word(8'h33, 1'b0, 1'b0);
    check("ovr_w3_q", 32'(q), 32'h11);
    check("ovr_w3_valid", 32'(q_valid), 32'h1);
    check("ovr_w3_overrun", 32'(overrun), 32'h1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_pop1_q", 32'(q), 32'h22);
    check("ovr_pop1_valid", 32'(q_valid), 32'h1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_pop2_valid", 32'(q_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clear", 32'(overrun), 32'h0);

    // Full buffer, pop on the completing edge of the third word
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b1);
    check("full_pop_q", 32'(q), 32'h22);
    check("full_pop_overrun", 32'(overrun), 32'h0);
    check("full_pop_valid", 32'(q_valid), 32'h1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("full_pop2_q", 32'(q), 32'h33);
    check("full_pop2_valid", 32'(q_valid), 32'h1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("full_pop3_valid", 32'(q_valid), 32'h0);

    // Resync: 4 bits of a word, then FRAME again starting 5A
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    check("resync_q", 32'(q), 32'h5A);
    check("resync_valid", 32'(q_valid), 32'h1);
    check("resync_overrun", 32'(overrun), 32'h0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("resync_single", 32'(q_valid), 32'h0);

    // Async reset mid-word with a word still buffered
    send_word(8'h3C, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_q", 32'(q), 32'h0);
    check("midrst_valid", 32'(q_valid), 32'h0);
    #1;
    rst = 1'b0;
    send_word(8'hC3, 1'b0, 1'b0);
    check("postrst_q", 32'(q), 32'hC3);
    check("postrst_valid", 32'(q_valid), 32'h1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DFFNQ_DESER_PARITY_EN
    send_word(8'hA5, 1'b0, 1'b0);
    check("par_ok_q", 32'(q), 32'hA5);
    check("par_ok_perr", 32'(q_perr), 32'h0);
    send_word(8'hA5, 1'b1, 1'b0);
    check("par_bad_head_perr", 32'(q_perr), 32'h0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("par_bad_q", 32'(q), 32'hA5);
    check("par_bad_perr", 32'(q_perr), 32'h1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
`else
    send_word(8'h81, 1'b1, 1'b0);
    check("noparity_q", 32'(q), 32'h81);
    check("noparity_perr", 32'(q_perr), 32'h0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
